// File: rtl/am2940_pkg.sv
// Shared encodings for the Am2940-style DMA address generator.
// Latency: none (types and constants only).
// Backpressure: none (types and constants only).
package am2940_pkg;

    // Instruction encoding applied every clock
    typedef enum logic [2:0] {
        WR_CR   = 3'd0,
        RD_CR   = 3'd1,
        RD_WC   = 3'd2,
        RD_AC   = 3'd3,
        REINIT  = 3'd4,
        LD_ADDR = 3'd5,
        LD_WC   = 3'd6,
        ENABLE  = 3'd7
    } instr_e;

    // Control register mode field values
    localparam logic [1:0] MODE_WC_DOWN  = 2'd0;  // word counter counts down to 01
    localparam logic [1:0] MODE_WC_CMP   = 2'd1;  // word counter counts up, compared to WCR
    localparam logic [1:0] MODE_AC_CMP   = 2'd2;  // address counter compared to WCR
    localparam logic [1:0] MODE_WC_CARRY = 2'd3;  // word counter counts up, no done

    // Control register field positions
    localparam int CR_MODE_LO = 0;
    localparam int CR_MODE_HI = 1;
    localparam int CR_DIR_BIT = 2;

    // Upward-counting word modes start from zero instead of the reload value
    function automatic logic mode_clears_wc(input logic [1:0] mode);
        return (mode == MODE_WC_CMP) || (mode == MODE_WC_CARRY);
    endfunction

endpackage

// File: rtl/am2940_updown_cnt8.sv
// 8-bit up/down counter with clear, load and active-low carry chain.
// Latency: 1 clock from clear/load/step to o_q; carry-out is combinational.
// Backpressure: none; counting is gated only by the active-low carry-in.
module am2940_updown_cnt8 (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_clear,
    input  logic       i_load,
    input  logic [7:0] i_load_val,
    input  logic       i_step,
    input  logic       i_dn,
    input  logic       i_ci_n,
    output logic [7:0] o_q,
    output logic       o_co_n
);

    logic [7:0] r_q;
    logic       w_terminal;

    // Count register: clear beats load beats step; a step needs carry-in asserted
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_q <= 8'h00;
        end else if (i_clear) begin
            r_q <= 8'h00;
        end else if (i_load) begin
            r_q <= i_load_val;
        end else if (i_step && !i_ci_n) begin
            r_q <= i_dn ? (r_q - 8'd1) : (r_q + 8'd1);
        end
    end

    // Terminal value depends on direction: 00 counting down, FF counting up
    assign w_terminal = i_dn ? (r_q == 8'h00) : (r_q == 8'hFF);
    assign o_co_n     = ~(~i_ci_n & w_terminal);
    assign o_q        = r_q;

endmodule

// File: rtl/am2940_dma_addr_gen.sv
// 8-bit DMA address/word-count generator driven by a 3-bit instruction per clock.
// Latency: register updates land 1 clock after the instruction; read-back, carries and done are combinational.
// Backpressure: none; counters advance only on ENABLE with the matching carry-in low.
module am2940_dma_addr_gen
    import am2940_pkg::*;
(
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic [7:0] i_data_in,
    input  logic [2:0] i_instr,
    input  logic       i_aci_n,
    input  logic       i_wci_n,
    output logic [7:0] o_addr_out,
    output logic [7:0] o_data_out,
    output logic       o_data_oe,
    output logic       o_aco_n,
    output logic       o_wco_n,
    output logic       o_done
);

    logic [2:0] r_cr;
    logic [7:0] r_ar;
    logic [7:0] r_wcr;

    instr_e     w_instr;
    logic [1:0] w_mode;
    logic       w_ac_dn;
    logic       w_wc_dn;
    logic [7:0] w_ac;
    logic [7:0] w_wc;
    logic [7:0] w_wc_inc;

    logic       w_ac_load;
    logic [7:0] w_ac_load_val;
    logic       w_wc_clear;
    logic       w_wc_load;
    logic [7:0] w_wc_load_val;
    logic       w_step;

    assign w_instr = instr_e'(i_instr);
    assign w_mode  = r_cr[CR_MODE_HI:CR_MODE_LO];
    assign w_ac_dn = r_cr[CR_DIR_BIT];
    assign w_wc_dn = (w_mode == MODE_WC_DOWN);
    assign w_step  = (w_instr == ENABLE);

    // Control, address and word-count reload registers
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_cr  <= 3'b000;
            r_ar  <= 8'h00;
            r_wcr <= 8'h00;
        end else begin
            if (w_instr == WR_CR)   r_cr  <= i_data_in[2:0];
            if (w_instr == LD_ADDR) r_ar  <= i_data_in;
            if (w_instr == LD_WC)   r_wcr <= i_data_in;
        end
    end

    // Counter control decode: loads and counting are exclusive by instruction
    always_comb begin
        w_ac_load     = 1'b0;
        w_ac_load_val = r_ar;
        w_wc_clear    = 1'b0;
        w_wc_load     = 1'b0;
        w_wc_load_val = r_wcr;
        case (w_instr)
            WR_CR: begin
                // The new mode, not the current one, decides whether WC restarts at zero
                w_wc_clear = mode_clears_wc(i_data_in[1:0]);
            end
            REINIT: begin
                w_ac_load  = 1'b1;
                w_wc_clear = mode_clears_wc(w_mode);
                w_wc_load  = !mode_clears_wc(w_mode);
            end
            LD_ADDR: begin
                w_ac_load     = 1'b1;
                w_ac_load_val = i_data_in;
            end
            LD_WC: begin
                w_wc_clear    = mode_clears_wc(w_mode);
                w_wc_load     = !mode_clears_wc(w_mode);
                w_wc_load_val = i_data_in;
            end
            default: ;
        endcase
    end

    am2940_updown_cnt8 u_ac (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (1'b0),
        .i_load     (w_ac_load),
        .i_load_val (w_ac_load_val),
        .i_step     (w_step),
        .i_dn       (w_ac_dn),
        .i_ci_n     (i_aci_n),
        .o_q        (w_ac),
        .o_co_n     (o_aco_n)
    );

    am2940_updown_cnt8 u_wc (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (w_wc_clear),
        .i_load     (w_wc_load),
        .i_load_val (w_wc_load_val),
        .i_step     (w_step),
        .i_dn       (w_wc_dn),
        .i_ci_n     (i_wci_n),
        .o_q        (w_wc),
        .o_co_n     (o_wco_n)
    );

    assign o_addr_out = w_ac;

    // Read-back mux; bus is driven only for the three read instructions
    always_comb begin
        o_data_out = 8'h00;
        o_data_oe  = 1'b0;
        case (w_instr)
            RD_CR: begin
                o_data_out = {5'b11111, r_cr};
                o_data_oe  = 1'b1;
            end
            RD_WC: begin
                o_data_out = w_wc;
                o_data_oe  = 1'b1;
            end
            RD_AC: begin
                o_data_out = w_ac;
                o_data_oe  = 1'b1;
            end
            default: ;
        endcase
    end

    assign w_wc_inc = w_wc + 8'd1;

    // Transfer-complete detection per mode
    always_comb begin
        o_done = 1'b0;
        case (w_mode)
            MODE_WC_DOWN:  o_done = (w_wc == 8'h01) && !i_wci_n;
            MODE_WC_CMP:   o_done = (w_wc_inc == r_wcr) && !i_wci_n;
            MODE_AC_CMP:   o_done = (w_ac == r_wcr);
            MODE_WC_CARRY: o_done = 1'b0;
            default:       o_done = 1'b0;
        endcase
    end

endmodule

// File: tb/tb_am2940_dma_addr_gen.sv
module tb_am2940_dma_addr_gen;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic [7:0] i_data_in = 8'h00;
    logic [2:0] i_instr = 3'd0;
    logic       i_aci_n = 1'b1;
    logic       i_wci_n = 1'b1;
    logic [7:0] o_addr_out;
    logic [7:0] o_data_out;
    logic       o_data_oe;
    logic       o_aco_n;
    logic       o_wco_n;
    logic       o_done;

    int checks = 0;
    int errors = 0;

    // Reference state
    logic [2:0] m_cr;
    logic [7:0] m_ar, m_ac, m_wcr, m_wc;

    am2940_dma_addr_gen dut (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_data_in  (i_data_in),
        .i_instr    (i_instr),
        .i_aci_n    (i_aci_n),
        .i_wci_n    (i_wci_n),
        .o_addr_out (o_addr_out),
        .o_data_out (o_data_out),
        .o_data_oe  (o_data_oe),
        .o_aco_n    (o_aco_n),
        .o_wco_n    (o_wco_n),
        .o_done     (o_done)
    );

    always #5 i_clk = ~i_clk;

    initial begin
        #2000000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    // Reference model: one clock of the register file as described by the instruction set
    task automatic model_step();
        logic [1:0] mode;
        mode = m_cr[1:0];
        if (i_rst) begin
            m_cr = 3'b000; m_ar = 8'h00; m_ac = 8'h00; m_wcr = 8'h00; m_wc = 8'h00;
        end else begin
            case (i_instr)
                3'd0: begin
                    m_cr = i_data_in[2:0];
                    if (i_data_in[1:0] == 2'd1 || i_data_in[1:0] == 2'd3) m_wc = 8'h00;
                end
                3'd4: begin
                    m_ac = m_ar;
                    m_wc = (mode == 2'd0 || mode == 2'd2) ? m_wcr : 8'h00;
                end
                3'd5: begin
                    m_ar = i_data_in;
                    m_ac = i_data_in;
                end
                3'd6: begin
                    m_wcr = i_data_in;
                    m_wc  = (mode == 2'd0 || mode == 2'd2) ? i_data_in : 8'h00;
                end
                3'd7: begin
                    if (!i_aci_n) m_ac = m_cr[2] ? m_ac - 8'd1 : m_ac + 8'd1;
                    if (!i_wci_n) m_wc = (mode == 2'd0) ? m_wc - 8'd1 : m_wc + 8'd1;
                end
                default: ;
            endcase
        end
    endtask

    function automatic logic [7:0] exp_data_out();
        case (i_instr)
            3'd1:    return {5'b11111, m_cr};
            3'd2:    return m_wc;
            3'd3:    return m_ac;
            default: return 8'h00;
        endcase
    endfunction

    function automatic logic exp_aco_n();
        logic term;
        term = m_cr[2] ? (m_ac == 8'h00) : (m_ac == 8'hFF);
        return !(!i_aci_n && term);
    endfunction

    function automatic logic exp_wco_n();
        logic term;
        term = (m_cr[1:0] == 2'd0) ? (m_wc == 8'h00) : (m_wc == 8'hFF);
        return !(!i_wci_n && term);
    endfunction

    function automatic logic exp_done();
        logic [7:0] nxt;
        nxt = m_wc + 8'd1;
        case (m_cr[1:0])
            2'd0:    return (m_wc == 8'h01) && !i_wci_n;
            2'd1:    return (nxt == m_wcr) && !i_wci_n;
            2'd2:    return (m_ac == m_wcr);
            default: return 1'b0;
        endcase
    endfunction

    // Drive inputs mid-cycle and let combinational outputs settle
    task automatic apply(input logic [2:0] ins, input logic [7:0] d,
                         input logic a, input logic w, input logic r);
        @(negedge i_clk);
        i_instr = ins; i_data_in = d; i_aci_n = a; i_wci_n = w; i_rst = r;
        #1;
    endtask

    // Take the rising edge and advance the reference model with the same inputs
    task automatic commit();
        @(posedge i_clk);
        model_step();
    endtask

    task automatic test_reset();
        apply(3'd7, 8'hA5, 1'b0, 1'b0, 1'b1);
        commit();
        apply(3'd1, 8'h00, 1'b1, 1'b1, 1'b0);
        checks++; if (o_addr_out !== 8'h00) begin errors++; $display("FAIL reset_addr got %h want 00", o_addr_out); end
        checks++; if (o_data_out !== 8'hF8) begin errors++; $display("FAIL reset_cr got %h want f8", o_data_out); end
        checks++; if (o_data_oe !== 1'b1) begin errors++; $display("FAIL reset_oe got %b want 1", o_data_oe); end
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL reset_done got %b want 0", o_done); end
        checks++; if (o_aco_n !== 1'b1 || o_wco_n !== 1'b1) begin errors++; $display("FAIL reset_carry got %b%b want 11", o_aco_n, o_wco_n); end
        commit();
    endtask

    task automatic test_read_cr();
        apply(3'd0, 8'h03, 1'b1, 1'b1, 1'b0); commit();
        apply(3'd1, 8'h00, 1'b1, 1'b1, 1'b0);
        checks++; if (o_data_out !== 8'hFB || o_data_oe !== 1'b1) begin errors++; $display("FAIL read_cr got %h/%b want fb/1", o_data_out, o_data_oe); end
        commit();
    endtask

    task automatic test_load_addr();
        apply(3'd0, 8'h00, 1'b1, 1'b1, 1'b0); commit();
        apply(3'd5, 8'h88, 1'b1, 1'b1, 1'b0);
        checks++; if (o_data_oe !== 1'b0 || o_data_out !== 8'h00) begin errors++; $display("FAIL ld_addr_bus got %h/%b want 00/0", o_data_out, o_data_oe); end
        commit();
        apply(3'd3, 8'h00, 1'b1, 1'b1, 1'b0);
        checks++; if (o_addr_out !== 8'h88 || o_data_out !== 8'h88) begin errors++; $display("FAIL ld_addr got %h/%h want 88/88", o_addr_out, o_data_out); end
        commit();
    endtask

    task automatic test_count_mode0();
        apply(3'd6, 8'h03, 1'b1, 1'b1, 1'b0); commit();
        apply(3'd7, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL m0_done_early got %b want 0", o_done); end
        commit();
        apply(3'd7, 8'h00, 1'b0, 1'b0, 1'b0);
        checks++; if (o_addr_out !== 8'h89) begin errors++; $display("FAIL m0_ac1 got %h want 89", o_addr_out); end
        commit();
        apply(3'd2, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (o_addr_out !== 8'h8A || o_data_out !== 8'h01) begin errors++; $display("FAIL m0_count got %h/%h want 8a/01", o_addr_out, o_data_out); end
        checks++; if (o_done !== 1'b1) begin errors++; $display("FAIL m0_done got %b want 1", o_done); end
        commit();
    endtask

    task automatic test_dec_wrap();
        apply(3'd0, 8'h04, 1'b1, 1'b1, 1'b0); commit();
        apply(3'd5, 8'h00, 1'b1, 1'b1, 1'b0); commit();
        apply(3'd3, 8'h00, 1'b1, 1'b1, 1'b0);
        checks++; if (o_aco_n !== 1'b1) begin errors++; $display("FAIL dec_aco_idle got %b want 1", o_aco_n); end
        commit();
        apply(3'd7, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if (o_aco_n !== 1'b0) begin errors++; $display("FAIL dec_aco got %b want 0", o_aco_n); end
        commit();
        apply(3'd7, 8'h00, 1'b1, 1'b1, 1'b0);
        checks++; if (o_addr_out !== 8'hFF || o_aco_n !== 1'b1) begin errors++; $display("FAIL dec_wrap got %h/%b want ff/1", o_addr_out, o_aco_n); end
        commit();
        apply(3'd3, 8'h00, 1'b1, 1'b1, 1'b0);
        checks++; if (o_addr_out !== 8'hFF) begin errors++; $display("FAIL dec_hold got %h want ff", o_addr_out); end
        commit();
    endtask

    task automatic test_mode1();
        apply(3'd0, 8'h01, 1'b1, 1'b1, 1'b0); commit();
        apply(3'd6, 8'h04, 1'b1, 1'b1, 1'b0); commit();
        apply(3'd2, 8'h00, 1'b1, 1'b1, 1'b0);
        checks++; if (o_data_out !== 8'h00) begin errors++; $display("FAIL m1_ldwc got %h want 00", o_data_out); end
        commit();
        for (int i = 0; i < 3; i++) begin
            apply(3'd7, 8'h00, 1'b1, 1'b0, 1'b0); commit();
        end
        apply(3'd2, 8'h00, 1'b1, 1'b0, 1'b0);
        checks++; if (o_data_out !== 8'h03 || o_done !== 1'b1) begin errors++; $display("FAIL m1_count got %h/%b want 03/1", o_data_out, o_done); end
        commit();
        apply(3'd4, 8'h00, 1'b1, 1'b1, 1'b0); commit();
        apply(3'd2, 8'h00, 1'b1, 1'b1, 1'b0);
        checks++; if (o_data_out !== 8'h00 || o_addr_out !== 8'h00) begin errors++; $display("FAIL m1_reinit got %h/%h want 00/00", o_data_out, o_addr_out); end
        commit();
    endtask

    task automatic test_reset_midcount();
        apply(3'd0, 8'h00, 1'b1, 1'b1, 1'b0); commit();
        apply(3'd6, 8'h10, 1'b1, 1'b1, 1'b0); commit();
        apply(3'd5, 8'h40, 1'b1, 1'b1, 1'b0); commit();
        apply(3'd7, 8'h00, 1'b0, 1'b0, 1'b0); commit();
        apply(3'd7, 8'h00, 1'b0, 1'b0, 1'b1); commit();
        apply(3'd1, 8'h00, 1'b1, 1'b1, 1'b0);
        checks++; if (o_addr_out !== 8'h00 || o_data_out !== 8'hF8 || o_done !== 1'b0) begin errors++; $display("FAIL mid_rst got %h/%h/%b want 00/f8/0", o_addr_out, o_data_out, o_done); end
        commit();
        apply(3'd2, 8'h00, 1'b1, 1'b1, 1'b0);
        checks++; if (o_data_out !== 8'h00) begin errors++; $display("FAIL mid_rst_wc got %h want 00", o_data_out); end
        commit();
    endtask

    task automatic test_mode2_done();
        apply(3'd0, 8'h02, 1'b1, 1'b1, 1'b0); commit();
        apply(3'd6, 8'h55, 1'b1, 1'b1, 1'b0); commit();
        apply(3'd5, 8'h54, 1'b1, 1'b1, 1'b0); commit();
        apply(3'd7, 8'h00, 1'b0, 1'b1, 1'b0);
        checks++; if (o_done !== 1'b0) begin errors++; $display("FAIL m2_not_done got %b want 0", o_done); end
        commit();
        apply(3'd3, 8'h00, 1'b1, 1'b1, 1'b0);
        checks++; if (o_done !== 1'b1 || o_data_out !== 8'h55) begin errors++; $display("FAIL m2_done got %b/%h want 1/55", o_done, o_data_out); end
        commit();
    endtask

    task automatic test_random();
        logic [2:0] ins;
        logic [7:0] d;
        logic       a, w, r;
        for (int n = 0; n < 600; n++) begin
            ins = 3'($urandom_range(0, 7));
            // Bias toward ENABLE so counters travel far enough to wrap
            if ($urandom_range(0, 2) == 0) ins = 3'd7;
            d = 8'($urandom);
            if ($urandom_range(0, 3) == 0) d = ($urandom_range(0, 1) == 0) ? 8'h00 : 8'hFF;
            a = 1'($urandom_range(0, 1));
            w = 1'($urandom_range(0, 1));
            r = ($urandom_range(0, 49) == 0);
            apply(ins, d, a, w, r);
            checks++; if (o_addr_out !== m_ac) begin errors++; $display("FAIL rnd_addr n=%0d got %h want %h", n, o_addr_out, m_ac); end
            checks++; if (o_data_out !== exp_data_out()) begin errors++; $display("FAIL rnd_data n=%0d got %h want %h", n, o_data_out, exp_data_out()); end
            checks++; if (o_data_oe !== (ins >= 3'd1 && ins <= 3'd3)) begin errors++; $display("FAIL rnd_oe n=%0d got %b", n, o_data_oe); end
            checks++; if (o_aco_n !== exp_aco_n()) begin errors++; $display("FAIL rnd_aco n=%0d got %b want %b", n, o_aco_n, exp_aco_n()); end
            checks++; if (o_wco_n !== exp_wco_n()) begin errors++; $display("FAIL rnd_wco n=%0d got %b want %b", n, o_wco_n, exp_wco_n()); end
            checks++; if (o_done !== exp_done()) begin errors++; $display("FAIL rnd_done n=%0d got %b want %b", n, o_done, exp_done()); end
            commit();
        end
    endtask

    initial begin
        m_cr = 3'b000; m_ar = 8'h00; m_ac = 8'h00; m_wcr = 8'h00; m_wc = 8'h00;
        test_reset();
        test_read_cr();
        test_load_addr();
        test_count_mode0();
        test_dec_wrap();
        test_mode1();
        test_reset_midcount();
        test_mode2_done();
        test_random();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
